seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 12500, clock cycles per digit slot (>= BLANK_CYCLES+16).
REQ-003 SHALL have parameter BLANK_CYCLES, default 64, anti-ghost blank cycles at the start of each slot.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1, inverts seg_o when 1.
REQ-005 SHALL have parameter DIG_ACTIVE_LOW, default 1, inverts dig_o when 1.
REQ-006 SHALL have one clock and synchronous active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, synchronous, active-low.
REQ-007 SHALL have wr_en_i input 1: write strobe for one digit register.
REQ-008 SHALL have wr_addr_i input AW=$clog2(NUM_DIGITS): digit index to write.
REQ-009 SHALL have wr_data_i input 7: segment pattern, bit0=a .. bit6=g, 1=lit; taken directly from the animator seg_o.
REQ-010 SHALL have brightness_i input 4: PWM duty level 0..15.
REQ-011 SHALL have blank_i input 1: forces all digits off.
REQ-012 SHALL have seg_o output 7: segment drive to the pins.
REQ-013 SHALL have dig_o output NUM_DIGITS: one-hot digit enable to the pins.
REQ-014 SHALL have frame_o output 1: one-cycle pulse at the end of the last digit slot.

Function
REQ-015 Writes: with wr_en_i=1 and wr_addr_i<NUM_DIGITS, digit register updates on the next edge; writes with an out-of-range address are ignored.
REQ-016 Scan: slot counter counts 0..SCAN_DIV-1; at wrap, the digit index advances, and from NUM_DIGITS-1 it wraps to 0.
REQ-017 FSM states: BLANK (slot count < BLANK_CYCLES) and ON (remainder of slot); BLANK->ON at count BLANK_CYCLES; ON->BLANK at slot wrap.
REQ-018 In BLANK: all dig_o inactive and seg_o all unlit.
REQ-019 On BLANK->ON entry, the current digit register is latched into a display register; writes during ON are shown in that digit's next slot, with no tearing.
REQ-020 A write in the same cycle as the latch is not shown in that slot.
REQ-021 PWM: a 4-bit counter clears on ON entry and increments every ON cycle; digit is lit iff pwm_cnt < brightness_i (0=off, 15=15/16 duty).
REQ-022 When lit: dig_o is one-hot at the current index and seg_o equals the display register; otherwise both are inactive.
REQ-023 Polarity inversion is applied at the outputs only; "inactive" means all-0 before inversion.
REQ-024 blank_i=1 forces outputs inactive from the next cycle; scan counters keep running.
REQ-025 frame_o=1 for exactly the cycle in which the slot counter wraps with index NUM_DIGITS-1.
REQ-026 Outputs are registered: one cycle latency from internal state to pins.
REQ-027 brightness_i is sampled every cycle; no latching.

Reset
REQ-028 While rst_ni=0 at an edge: digit registers=0, display register=0, slot counter=0, index=0, pwm_cnt=0, state=BLANK, frame_o=0.
REQ-029 During reset, seg_o and dig_o are driven inactive at the pins: all-1 if active-low, all-0 if active-high.
REQ-030 Reset asserted mid-slot takes effect at the next edge; scanning restarts at digit 0 BLANK after release.

Structure
REQ-031 A shared package seg7_pkg SHALL hold the segment bit-order constants (SEG_A..SEG_G), the scan state enum (BLANK, ON) and the default SCAN_DIV/BLANK_CYCLES values.
REQ-032 The PWM compare SHALL be a sub-module seg7_pwm (4-bit counter, clear, enable, level in, lit out); the remaining logic is in one module.

Verification (NUM_DIGITS=4, SCAN_DIV=24, BLANK_CYCLES=4, active-low)
REQ-033 Reset: hold rst_ni=0 for 3 cycles -> seg_o=7'h7F, dig_o=4'hF, frame_o=0.
REQ-034 Write 7'h01,7'h02,7'h04,7'h08 to digits 0..3 with brightness=15 -> each 24-cycle slot shows 4 blank cycles, then dig_o=~(1<<i), seg_o=~pattern on 15 of every 16 ON cycles; frame_o pulses once per 96 cycles.
REQ-035 brightness=0 -> dig_o stays 4'hF; brightness=8 -> lit on exactly 8 of the first 16 ON cycles of each slot.
REQ-036 Write 7'h7F to digit 1 mid-way through digit 1's ON phase -> old pattern kept for the rest of that slot, 7'h7F shown next frame; a write to digit 5 (AW=2 wraps impossible, use NUM_DIGITS=3 addr 3) is ignored.
REQ-037 Assert blank_i for 30 cycles mid-frame -> outputs inactive for those cycles; frame_o period unchanged at 96.
REQ-038 Deassert rst_ni during digit 2 ON -> outputs inactive next edge; after release, digit 0 becomes active at cycle 5 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order, scan
// state encoding and default slot timing.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam int SCAN_DIV_DEF     = 12500;
   localparam int BLANK_CYCLES_DEF = 64;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg7_pwm.sv
// Brightness PWM for one digit slot: a free 4-bit counter restarted at the
// start of each ON phase, lit while the count is below the requested level.
module seg7_pwm (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [3:0] level_i,
   output logic       lit_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // level 15 leaves one dark count in 16; level 0 never lights
   assign lit_o = (cnt_q < level_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: per-digit pattern registers, slot timing
// with an anti-ghost blank lead-in, PWM dimming and registered pin drive.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = SCAN_DIV_DEF,
   parameter int BLANK_CYCLES   = BLANK_CYCLES_DEF,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          wr_en_i,
   input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr_i,
   input  logic [6:0]                    wr_data_i,
   input  logic [3:0]                    brightness_i,
   input  logic                          blank_i,
   output logic [6:0]                    seg_o,
   output logic [NUM_DIGITS-1:0]         dig_o,
   output logic                          frame_o
);

   localparam int AW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] SLOT_ENTRY = CW'(BLANK_CYCLES - 1);
   localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

   logic [6:0]            digit_q [NUM_DIGITS];
   logic [6:0]            disp_q, disp_d;
   logic [CW-1:0]         slot_q, slot_d;
   logic [AW-1:0]         idx_q, idx_d;
   scan_state_e           state_q, state_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic                  frame_q, frame_d;

   logic slot_wrap, on_entry, pwm_lit, lit, wr_ok;

   assign wr_ok = ({1'b0, wr_addr_i} < (AW + 1)'(NUM_DIGITS));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      end else if (wr_en_i && wr_ok) begin
         digit_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign slot_wrap = (slot_q == SLOT_LAST);
   assign on_entry  = (state_q == BLANK) && (slot_q == SLOT_ENTRY);

   seg7_pwm u_pwm (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (on_entry),
      .en_i    (state_q == ON),
      .level_i (brightness_i),
      .lit_o   (pwm_lit)
   );

   assign lit = (state_q == ON) && pwm_lit && !blank_i;

   always_comb begin
      slot_d  = slot_wrap ? '0 : slot_q + CW'(1);
      idx_d   = idx_q;
      state_d = state_q;
      disp_d  = disp_q;
      if (slot_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
      end
      case (state_q)
         BLANK: if (slot_q == SLOT_ENTRY) state_d = ON;
         ON:    if (slot_wrap)            state_d = BLANK;
         default: state_d = BLANK;
      endcase
      // snapshot at ON entry so a mid-slot write never tears the shown digit
      if (on_entry) begin
         disp_d = digit_q[idx_q];
      end
      seg_d   = lit ? disp_q : '0;
      dig_d   = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
      frame_d = slot_wrap && (idx_q == IDX_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         slot_q  <= '0;
         idx_q   <= '0;
         state_q <= BLANK;
         disp_q  <= '0;
         seg_q   <= '0;
         dig_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         disp_q  <= disp_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         frame_q <= frame_d;
      end
   end

   // registers hold active-high values; pin polarity is applied here only
   assign seg_o   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
   assign dig_o   = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit and a 3-digit instance share one
// stimulus stream and are compared every cycle against a slot-arithmetic model.
module tb_seg7_scan_driver;

   localparam int SD = 24;
   localparam int BC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [6:0] wr_data;
   logic [3:0] bright;
   logic       blank;

   logic [6:0] seg4, seg3;
   logic [3:0] dig4;
   logic [2:0] dig3;
   logic       frame4, frame3;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .brightness_i(bright), .blank_i(blank),
      .seg_o(seg4), .dig_o(dig4), .frame_o(frame4));

   seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                      .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .brightness_i(bright), .blank_i(blank),
      .seg_o(seg3), .dig_o(dig3), .frame_o(frame3));

   int npass = 0;
   int ntotal = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int ndig(input int k);
      return (k == 0) ? 4 : 3;
   endfunction

   // ---------------- reference model ----------------
   // t = cycles since reset release; the slot, digit and PWM phase follow
   // from plain division of t. Expected pins are those after the coming edge.
   int         t_m    [2];
   logic [6:0] mem    [2][8];
   logic [6:0] disp_m [2];
   logic [6:0] exp_seg [2];
   logic [7:0] exp_dig [2];
   logic       exp_frame [2];
   bit         mvalid = 0;
   int         m_pos, m_dg;
   bit         m_lit;
   logic [6:0] raw_seg;
   logic [7:0] raw_dig, m_mask;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         raw_seg = '0;
         raw_dig = '0;
         exp_frame[k] = 1'b0;
         if (!rst_n) begin
            t_m[k] = 0;
            disp_m[k] = '0;
            for (int j = 0; j < 8; j++) mem[k][j] = '0;
         end else begin
            m_pos = t_m[k] % SD;
            m_dg  = (t_m[k] / SD) % ndig(k);
            m_lit = (m_pos >= BC) && (((m_pos - BC) % 16) < int'(bright)) && !blank;
            if (m_lit) begin
               raw_seg = disp_m[k];
               raw_dig = 8'(1 << m_dg);
            end
            exp_frame[k] = (m_pos == SD - 1) && (m_dg == ndig(k) - 1);
            if (m_pos == BC - 1) disp_m[k] = mem[k][m_dg];
            if (wr_en && int'(wr_addr) < ndig(k)) mem[k][wr_addr] = wr_data;
            t_m[k]++;
         end
         m_mask = 8'((1 << ndig(k)) - 1);
         exp_seg[k] = ~raw_seg;
         exp_dig[k] = ~raw_dig & m_mask;
      end
      mvalid = 1;
   end

   // ---------------- per-cycle compare ----------------
   int cyc = 0;
   int prev_frame = 0;
   bit have_prev = 0;

   always @(negedge clk) begin
      cyc++;
      if (mvalid) begin
         chk("seg4", 32'(seg4), 32'(exp_seg[0]));
         chk("dig4", 32'(dig4), 32'(exp_dig[0]));
         chk("frame4", 32'(frame4), 32'(exp_frame[0]));
         chk("seg3", 32'(seg3), 32'(exp_seg[1]));
         chk("dig3", 32'(dig3), 32'(exp_dig[1]));
         chk("frame3", 32'(frame3), 32'(exp_frame[1]));
      end
      if (!rst_n) begin
         have_prev = 0;
      end else if (frame4) begin
         if (have_prev) chk("frame_period", 32'(cyc - prev_frame), 32'd96);
         prev_frame = cyc;
         have_prev = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_dig4(input logic [3:0] v, input string nm);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick(1);
         if (dig4 == v) found = 1;
      end
      if (!found) chk(nm, 32'd0, 32'd1);
   endtask

   int cnt_a, cnt_b;

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      bright = 4'd15; blank = 1'b0;
      tick(3);
      chk("rst_seg", 32'(seg4), 32'h7F);
      chk("rst_dig", 32'(dig4), 32'hF);
      chk("rst_frame", 32'(frame4), 32'h0);

      // release and load 01,02,04,08 into digits 0..3
      rst_n = 1'b1;
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 7'h01; tick(1);
      wr_addr = 2'd1; wr_data = 7'h02; tick(1);
      wr_addr = 2'd2; wr_data = 7'h04; tick(1);
      wr_addr = 2'd3; wr_data = 7'h08; tick(1);
      wr_en = 1'b0;
      tick(1);
      chk("first_dig4", 32'(dig4), 32'hE);
      chk("first_seg4", 32'(seg4), 32'h7E);
      chk("first_dig3", 32'(dig3), 32'h6);
      tick(200);

      // brightness 0: never lit
      bright = 4'd0;
      cnt_a = 0;
      repeat (96) begin tick(1); if (dig4 != 4'hF) cnt_a++; end
      chk("bright0_lit", 32'(cnt_a), 32'd0);

      // brightness 8: 8 + 4 lit cycles of the 20 ON cycles in every slot
      bright = 4'd8;
      cnt_a = 0; cnt_b = 0;
      repeat (96) begin
         tick(1);
         if (dig4 == 4'hE) cnt_a++;
         if (dig4 != 4'hF) cnt_b++;
      end
      chk("bright8_dig0", 32'(cnt_a), 32'd12);
      chk("bright8_all", 32'(cnt_b), 32'd48);
      bright = 4'd15;

      // write digit 1 mid-slot: old pattern held, new one next frame
      wait_dig4(4'hB, "wait_dig2");
      wait_dig4(4'hD, "wait_dig1");
      tick(5);
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 7'h7F; tick(1);
      wr_en = 1'b0;
      repeat (30) begin
         tick(1);
         if (dig4 == 4'hD) chk("old_pattern", 32'(seg4), 32'h7D);
      end
      wait_dig4(4'hD, "wait_dig1_next");
      chk("new_pattern", 32'(seg4), 32'h00);

      // out-of-range for the 3-digit instance
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 7'h55; tick(1);
      wr_en = 1'b0;

      // blank for 30 cycles mid-frame
      tick(37);
      blank = 1'b1;
      cnt_a = 0;
      repeat (30) begin
         tick(1);
         if (dig4 != 4'hF || seg4 != 7'h7F) cnt_a++;
      end
      blank = 1'b0;
      chk("blank_active", 32'(cnt_a), 32'd0);
      tick(100);

      // randomized traffic
      repeat (800) begin
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = 7'($urandom);
         if ($urandom_range(0, 7) == 0) bright = 4'($urandom);
         blank   = ($urandom_range(0, 15) == 0);
         tick(1);
      end
      wr_en = 1'b0; blank = 1'b0; bright = 4'd15;
      tick(50);

      // reset during digit 2 ON
      wait_dig4(4'hB, "wait_dig2_rst");
      rst_n = 1'b0;
      tick(1);
      chk("midrst_dig", 32'(dig4), 32'hF);
      chk("midrst_seg", 32'(seg4), 32'h7F);
      chk("midrst_frame", 32'(frame4), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(4);
      chk("rel_dig_c4", 32'(dig4), 32'hF);
      tick(1);
      chk("rel_dig_c5", 32'(dig4), 32'hE);
      chk("rel_seg_c5", 32'(seg4), 32'h7F);
      tick(100);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
